// File: rtl/plurality_voter_if.sv
// plurality_voter_if: vote input stream and result output stream of plurality_voter_seq.
// The tie signal exists only when VOTE_TIE_FLAG_EN is defined.
interface plurality_voter_if #(
  parameter int CAND_W = 2,
  parameter int CNT_W  = 4
);
  logic              vote_valid;
  logic              vote_ready;
  logic [CAND_W-1:0] vote_data;
  logic              res_valid;
  logic              res_ready;
  logic [CAND_W-1:0] winner;
  logic [CNT_W-1:0]  winner_count;
`ifdef VOTE_TIE_FLAG_EN
  logic              tie;
  modport master (output vote_valid, vote_data, res_ready,
                  input vote_ready, res_valid, winner, winner_count, tie);
  modport slave  (input vote_valid, vote_data, res_ready,
                  output vote_ready, res_valid, winner, winner_count, tie);
`else
  modport master (output vote_valid, vote_data, res_ready,
                  input vote_ready, res_valid, winner, winner_count);
  modport slave  (input vote_valid, vote_data, res_ready,
                  output vote_ready, res_valid, winner, winner_count);
`endif
endinterface

// File: rtl/plurality_voter_seq.sv
// plurality_voter_seq: collects N_VOTERS votes, tallies them, scans one candidate per cycle for the plurality winner.
// Optional VOTE_TIE_FLAG_EN adds a tie output flagging a shared maximal nonzero count.
module plurality_voter_seq #(
  parameter int  N_VOTERS = 8,
  parameter int  N_CAND   = 3,
  parameter int  CAND_W   = 2,
  localparam int CNT_W    = $clog2(N_VOTERS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  plurality_voter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;
  state_t            state, state_n;
  logic [CNT_W-1:0]  tally [1:N_CAND];
  logic [CNT_W-1:0]  cnt, best_cnt, win_cnt, nb_cnt, cur;
  logic [CAND_W-1:0] idx, best_code, win_code, nb_code;
  logic              accept, last, scan_end, take;
  assign cur = tally[idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    bus.vote_ready = state == COLLECT;
    bus.res_valid  = state == DONE;
    accept   = bus.vote_valid && state == COLLECT;
    last     = accept && cnt == CNT_W'(N_VOTERS - 1);
    scan_end = state == SCAN && idx == CAND_W'(N_CAND);
    take     = cur > best_cnt;
    nb_code  = take ? idx : best_code;
    nb_cnt   = take ? cur : best_cnt;
    state_n  = state == IDLE && start           ? COLLECT :
               last                              ? SCAN    :
               scan_end                          ? DONE    :
               state == DONE && bus.res_ready    ? IDLE    : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      best_code <= '0;
      best_cnt  <= '0;
      win_code  <= '0;
      win_cnt   <= '0;
      for (int c = 1; c <= N_CAND; c++) tally[c] <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        for (int c = 1; c <= N_CAND; c++) tally[c] <= '0;
      end
      // abstain codes advance the vote counter but match no tally slot
      if (accept) begin
        cnt <= cnt + 1'b1;
        for (int c = 1; c <= N_CAND; c++)
          if (bus.vote_data == CAND_W'(c)) tally[c] <= tally[c] + 1'b1;
      end
      if (last) begin
        idx       <= CAND_W'(1);
        best_code <= '0;
        best_cnt  <= '0;
      end
      if (state == SCAN) begin
        idx       <= idx + 1'b1;
        best_code <= nb_code;
        best_cnt  <= nb_cnt;
      end
      if (scan_end) begin
        win_code <= nb_code;
        win_cnt  <= nb_cnt;
      end
    end
  assign bus.winner       = win_code;
  assign bus.winner_count = win_cnt;
`ifdef VOTE_TIE_FLAG_EN
  logic tie_run, tie_out, tie_nx;
  // a new strict leader discards any tie found at a lower count
  assign tie_nx = take ? 1'b0 : (cur == best_cnt && best_cnt != '0) ? 1'b1 : tie_run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tie_run <= 1'b0;
      tie_out <= 1'b0;
    end else begin
      if (last) begin
        tie_run <= 1'b0;
        tie_out <= 1'b0;
      end
      if (state == SCAN) tie_run <= tie_nx;
      if (scan_end) tie_out <= tie_nx;
    end
  assign bus.tie = tie_out;
`endif
endmodule

// File: tb/tb_plurality_voter_seq.sv
// tb_plurality_voter_seq: directed and randomized rounds checked against a counting model of plurality voting.
module tb_plurality_voter_seq;
  localparam int NV = 8;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int NW = $clog2(NV + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int v[NV];
  plurality_voter_if #(.CAND_W(CW), .CNT_W(NW)) bus();
  plurality_voter_seq #(.N_VOTERS(NV), .N_CAND(NC), .CAND_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model(input int vs[NV], output int w, output int c, output int t);
    int tot[NC+1];
    int n;
    foreach (tot[k]) tot[k] = 0;
    foreach (vs[k]) if (vs[k] >= 1 && vs[k] <= NC) tot[vs[k]]++;
    w = 0; c = 0; n = 0;
    for (int k = 1; k <= NC; k++) if (tot[k] > c) begin c = tot[k]; w = k; end
    for (int k = 1; k <= NC; k++) if (c > 0 && tot[k] == c) n++;
    t = n > 1 ? 1 : 0;
  endtask
  task automatic round(input int vs[NV], input bit gaps, input int hold, input string tag);
    int w, c, t, i, guard, lat;
    bit ph;
    model(vs, w, c, t);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    i = 0; guard = 0; ph = 1'b1;
    while (i < NV && guard < 400) begin
      bus.vote_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      bus.vote_data = CW'(vs[i]);
      if (bus.vote_valid && bus.vote_ready) i++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_collected"}, i, NV);
    bus.vote_valid = 1'b0;
    check({tag, "_ready_drop"}, bus.vote_ready, 0);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      bus.vote_valid = 1'($urandom_range(0, 1));
      bus.vote_data = CW'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, NC);
    check({tag, "_winner"}, bus.winner, w);
    check({tag, "_count"}, bus.winner_count, c);
`ifdef VOTE_TIE_FLAG_EN
    check({tag, "_tie"}, bus.tie, t);
`endif
    repeat (hold) begin
      start = 1'($urandom_range(0, 1));
      bus.vote_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.res_valid, 1);
      check({tag, "_hold_winner"}, bus.winner, w);
      check({tag, "_hold_count"}, bus.winner_count, c);
    end
    bus.res_ready = 1'b1;
    start = 1'b1;
    bus.vote_valid = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    start = 1'b0;
    check({tag, "_valid_drop"}, bus.res_valid, 0);
    check({tag, "_idle_ready"}, bus.vote_ready, 0);
    @(negedge clk);
    check({tag, "_start_ignored"}, bus.vote_ready, 0);
    check({tag, "_winner_kept"}, bus.winner, w);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.vote_valid = 1'b0;
    bus.vote_data = '0;
    bus.res_ready = 1'b0;
    #12;
    check("rst_ready", bus.vote_ready, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_count", bus.winner_count, 0);
`ifdef VOTE_TIE_FLAG_EN
    check("rst_tie", bus.tie, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    v = '{1, 1, 1, 2, 2, 3, 0, 1};
    round(v, 1'b0, 0, "plain");
    v = '{3, 3, 2, 2, 0, 0, 0, 0};
    round(v, 1'b0, 2, "tiebreak");
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    round(v, 1'b0, 1, "abstain");
    v = '{2, 1, 3, 3, 1, 3, 0, 2};
    round(v, 1'b1, 5, "backpressure");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int i = 0;
      int guard = 0;
      while (i < 3 && guard < 50) begin
        bus.vote_valid = 1'b1;
        bus.vote_data = CW'(1);
        if (bus.vote_ready) i++;
        @(negedge clk);
        guard++;
      end
      check("abort_accepts", i, 3);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", bus.vote_ready, 0);
    check("abort_valid", bus.res_valid, 0);
    check("abort_winner", bus.winner, 0);
    bus.vote_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    v = '{2, 2, 2, 2, 3, 3, 3, 0};
    round(v, 1'b0, 0, "after_abort");
    for (int r = 0; r < 16; r++) begin
      foreach (v[k]) v[k] = int'($urandom_range(0, 3));
      round(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/plurality_voter_seq.md
Name: plurality_voter_seq

Overview:
- Sequential, parametrised successor to the combinational 8-voter / 3-candidate plurality voter.
- Collects N_VOTERS encoded votes over a valid/ready stream.
- Tallies votes per candidate, then scans the tallies to pick the winning candidate code and its count.
- Presents the result on a valid/ready output.
- Sits between a vote-source stream and downstream decision logic; one round per start pulse.

Parameters:
- N_VOTERS, 8, votes accepted per round (>=1).
- N_CAND, 3, number of candidates; valid candidate codes are 1..N_CAND.
- CAND_W, 2, vote/winner code width; must satisfy 2**CAND_W > N_CAND.
- CNT_W, $clog2(N_VOTERS+1), tally and winner_count width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a round; sampled only in IDLE.
- vote_valid  in  1  vote_data is valid.
- vote_ready  out  1  block accepts a vote this cycle.
- vote_data  in  CAND_W  candidate code; 0 or >N_CAND means abstain.
- res_valid  out  1  result is valid.
- res_ready  in  1  consumer takes the result.
- winner  out  CAND_W  winning candidate code; 0 if no candidate received a vote.
- winner_count  out  CNT_W  tally of the winner.
- tie  out  1  present only with VOTE_TIE_FLAG_EN.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; all tallies, vote counter and scan index cleared.
  - vote_ready=0, res_valid=0, winner=0, winner_count=0, tie=0.
  - Reset asserted mid-round aborts the round; no partial result is ever output.
- FSM states: IDLE, COLLECT, SCAN, DONE.
- IDLE:
  - start=1 -> COLLECT; all tallies and the vote counter cleared on the same edge.
  - start is ignored in every other state.
- COLLECT:
  - vote_ready=1.
  - A vote is accepted on an edge with vote_valid & vote_ready.
  - Accepted code c in 1..N_CAND increments tally[c]. Abstain codes are accepted and counted toward N_VOTERS but increment no tally.
  - On the edge accepting the N_VOTERS-th vote -> SCAN; vote_ready drops the next cycle.
  - vote_valid gaps stall collection indefinitely.
- SCAN (vote_ready=0):
  - Entered with best_code=0, best_cnt=0.
  - One candidate per cycle, index i=1..N_CAND: if tally[i] > best_cnt (strict) then best_code=i, best_cnt=tally[i].
  - Strict compare means ties resolve to the lowest code, and all-zero tallies yield winner=0, count=0.
  - After candidate N_CAND -> DONE.
  - res_valid rises exactly N_CAND cycles after the edge that accepted the last vote.
- DONE:
  - res_valid=1; winner and winner_count are held stable until the handshake.
  - Edge with res_valid & res_ready -> IDLE; res_valid=0 next cycle.
  - winner and winner_count keep their values until the next SCAN completes.
  - start is sampled only once back in IDLE.
- Arithmetic:
  - Tallies saturate at N_VOTERS by construction, so no overflow occurs.
  - All compares are unsigned, CNT_W wide.
- Simultaneous events:
  - start arriving in the same cycle as the result handshake is ignored.
  - vote_valid outside COLLECT is ignored and has no side effect.

Optional Feature:
- Macro: VOTE_TIE_FLAG_EN.
- Defined:
  - Adds output tie.
  - During SCAN, track whether a later candidate has tally == best_cnt with best_cnt > 0.
  - tie is valid with res_valid, held in DONE, and cleared when the next SCAN starts.
  - tie=1 iff two or more candidates share the maximal nonzero count.
- Undefined:
  - tie port and its logic are absent.
  - All other behaviour is identical.

Test Plan (defaults N_VOTERS=8, N_CAND=3, CAND_W=2):
- Plain plurality: start, then votes 1,1,1,2,2,3,0,1 back-to-back.
  - Required: winner=1, winner_count=4, tie=0.
  - res_valid high exactly 3 cycles after the 8th accept.
  - vote_ready=0 from the cycle after the 8th accept.
- Tie-break: votes 3,3,2,2,0,0,0,0.
  - Required: winner=2, winner_count=2, tie=1 (with macro).
- All abstain: eight votes of 0.
  - Required: winner=0, winner_count=0, tie=0.
- Backpressure:
  - Stimulus: vote_valid toggled 1/0 each cycle; res_ready held 0 for 5 cycles after res_valid; start pulsed during DONE.
  - Required: outputs stable throughout the stall; start ignored; IDLE reached the cycle after res_ready=1.
- Reset mid-collect: assert rst_n=0 asynchronously after 3 accepted votes (1,1,1).
  - Required: immediately vote_ready=0, res_valid=0, winner=0.
  - Next round with votes 2,2,2,2,3,3,3,0 -> winner=2, winner_count=4; no residue from the aborted round.
